// File: rtl/mux_scan_bank.sv
// mux_scan_bank: registered bank of shared-select N-to-1 selectors with an optional dwell-timed scan sequencer.
module mux_scan_bank #(
  parameter int CHANNELS  = 2,
  parameter int SEL_WIDTH = 2,
  parameter int DWELL     = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CHANNELS*(1<<SEL_WIDTH)-1:0] data_in,
  input  logic [CHANNELS-1:0]           enable_n,
  input  logic                          mode,
  input  logic [SEL_WIDTH-1:0]          select_in,
  input  logic                          scan_start,
  input  logic                          continuous,
  output logic [CHANNELS-1:0]           y,
  output logic [SEL_WIDTH-1:0]          y_select,
  output logic [SEL_WIDTH-1:0]          select_out,
  output logic                          sample_strobe,
  output logic                          scan_done,
  output logic                          scanning
);
  localparam int INPUTS = 1 << SEL_WIDTH;
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] LAST = DW'(DWELL - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;
  logic [SEL_WIDTH-1:0] sel_q, sel_nx;
  logic [DW-1:0] dwell_cnt, dwell_nx;
  logic strobe_nx, done_nx;
  logic [CHANNELS-1:0] y_nx;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [INPUTS-1:0] row;
    assign row = data_in[i*INPUTS +: INPUTS];
    assign y_nx[i] = ~enable_n[i] & row[sel_q];
  end
  always_comb begin
    state_nx  = state;
    sel_nx    = sel_q;
    dwell_nx  = dwell_cnt;
    strobe_nx = 1'b0;
    done_nx   = 1'b0;
    if (state == IDLE) begin
      if (!mode) sel_nx = select_in;
      else if (scan_start) begin
        state_nx = SCAN;
        sel_nx   = '0;
        dwell_nx = '0;
      end
    end else if (!mode) begin
      state_nx = IDLE;
      sel_nx   = select_in;
      dwell_nx = '0;
    end else if (dwell_cnt != LAST) begin
      dwell_nx = dwell_cnt + DW'(1);
    end else begin
      dwell_nx  = '0;
      strobe_nx = 1'b1;
      sel_nx    = sel_q + SEL_WIDTH'(1);
      if (sel_q == '1) begin
        done_nx  = 1'b1;
        state_nx = continuous ? SCAN : IDLE;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sel_q         <= '0;
      dwell_cnt     <= '0;
      y             <= '0;
      y_select      <= '0;
      sample_strobe <= 1'b0;
      scan_done     <= 1'b0;
    end else begin
      state         <= state_nx;
      sel_q         <= sel_nx;
      dwell_cnt     <= dwell_nx;
      y             <= y_nx;
      y_select      <= sel_q;
      sample_strobe <= strobe_nx;
      scan_done     <= done_nx;
    end
  end
  assign select_out = sel_q;
  assign scanning   = state == SCAN;
endmodule

// File: tb/tb_mux_scan_bank.sv
// tb_mux_scan_bank: directed checks of direct select, scan sequencing, abort, async reset and a wide configuration.
module tb_mux_scan_bank;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] data_in = '0;
  logic [1:0] enable_n = '0;
  logic mode = 1'b0;
  logic [1:0] select_in = '0;
  logic scan_start = 1'b0;
  logic continuous = 1'b0;
  logic [23:0] data2 = '0;
  logic [2:0] enable2 = '0;
  logic [2:0] select2 = '0;
  logic [1:0] y0, ys0, so0, y1, ys1, so1;
  logic st0, dn0, sc0, st1, dn1, sc1;
  logic [2:0] y2, ys2, so2;
  logic st2, dn2, sc2;
  int checks = 0;
  int errs = 0;

  always #5 clock = ~clock;

  mux_scan_bank u0 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .enable_n(enable_n), .mode(mode),
    .select_in(select_in), .scan_start(scan_start), .continuous(continuous), .y(y0),
    .y_select(ys0), .select_out(so0), .sample_strobe(st0), .scan_done(dn0), .scanning(sc0)
  );
  mux_scan_bank #(.DWELL(3)) u1 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .enable_n(enable_n), .mode(mode),
    .select_in(select_in), .scan_start(scan_start), .continuous(continuous), .y(y1),
    .y_select(ys1), .select_out(so1), .sample_strobe(st1), .scan_done(dn1), .scanning(sc1)
  );
  mux_scan_bank #(.CHANNELS(3), .SEL_WIDTH(3)) u2 (
    .clock(clock), .reset_n(reset_n), .data_in(data2), .enable_n(enable2), .mode(mode),
    .select_in(select2), .scan_start(scan_start), .continuous(continuous), .y(y2),
    .y_select(ys2), .select_out(so2), .sample_strobe(st2), .scan_done(dn2), .scanning(sc2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #2;
    checks++;
    if ({y0, ys0, so0, st0, dn0, sc0} !== 9'b0) begin
      errs++;
      $display("FAIL reset_u0 got=%b want=0", {y0, ys0, so0, st0, dn0, sc0});
    end
    checks++;
    if ({y2, ys2, so2, st2, dn2, sc2} !== 12'b0) begin
      errs++;
      $display("FAIL reset_u2 got=%b want=0", {y2, ys2, so2, st2, dn2, sc2});
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_direct;
    mode = 1'b0;
    data_in = 8'b1010_0110;
    enable_n = 2'b00;
    select_in = 2'd2;
    tick();
    checks++;
    if (so0 !== 2'd2 || ys0 !== 2'd0 || y0 !== 2'b00) begin
      errs++;
      $display("FAIL direct_lat1 so=%0d ys=%0d y=%b want so=2 ys=0 y=00", so0, ys0, y0);
    end
    tick();
    checks++;
    if (y0 !== 2'b01 || ys0 !== 2'd2) begin
      errs++;
      $display("FAIL direct_sel2 y=%b ys=%0d want y=01 ys=2", y0, ys0);
    end
    enable_n = 2'b01;
    tick();
    checks++;
    if (y0 !== 2'b00) begin
      errs++;
      $display("FAIL direct_en01 y=%b want 00", y0);
    end
    enable_n = 2'b00;
    select_in = 2'd1;
    tick();
    tick();
    checks++;
    if (y0 !== 2'b11 || ys0 !== 2'd1) begin
      errs++;
      $display("FAIL direct_sel1 y=%b ys=%0d want y=11 ys=1", y0, ys0);
    end
    enable_n = 2'b10;
    tick();
    checks++;
    if (y0 !== 2'b01) begin
      errs++;
      $display("FAIL direct_en10 y=%b want 01", y0);
    end
    enable_n = 2'b00;
  endtask

  task automatic test_scan;
    logic [1:0] exp_y [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    data_in = 8'b0001_1000;
    mode = 1'b1;
    continuous = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    checks++;
    if (sc0 !== 1'b1 || so0 !== 2'd0 || st0 !== 1'b0) begin
      errs++;
      $display("FAIL scan_start sc=%b so=%0d st=%b want sc=1 so=0 st=0", sc0, so0, st0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ys0 !== 2'(k) || y0 !== exp_y[k] || st0 !== 1'b1 || dn0 !== (k == 3) || sc0 !== (k != 3)) begin
        errs++;
        $display("FAIL scan_d1_%0d ys=%0d y=%b st=%b dn=%b sc=%b want ys=%0d y=%b st=1 dn=%b sc=%b",
                 k, ys0, y0, st0, dn0, sc0, k, exp_y[k], k == 3, k != 3);
      end
    end
    tick();
    checks++;
    if (st0 !== 1'b0 || dn0 !== 1'b0 || sc0 !== 1'b0 || so0 !== 2'd0) begin
      errs++;
      $display("FAIL scan_idle st=%b dn=%b sc=%b so=%0d want 0 0 0 0", st0, dn0, sc0, so0);
    end
  endtask

  task automatic test_back_to_back;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (4) tick();
    checks++;
    if (dn0 !== 1'b1) begin
      errs++;
      $display("FAIL b2b_done dn=%b want 1", dn0);
    end
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    checks++;
    if (sc0 !== 1'b1 || so0 !== 2'd0 || dn0 !== 1'b0) begin
      errs++;
      $display("FAIL b2b_restart sc=%b so=%0d dn=%b want sc=1 so=0 dn=0", sc0, so0, dn0);
    end
    tick();
    checks++;
    if (st0 !== 1'b1 || ys0 !== 2'd0) begin
      errs++;
      $display("FAIL b2b_first st=%b ys=%0d want st=1 ys=0", st0, ys0);
    end
    mode = 1'b0;
    select_in = 2'd0;
    tick();
  endtask

  task automatic test_continuous;
    logic [1:0] exp_y [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
    mode = 1'b1;
    continuous = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c == 27) continuous = 1'b0;
      tick();
      checks++;
      if (st1 !== (c % 3 == 0) || dn1 !== (c % 12 == 0) || ys1 !== 2'(((c - 1) / 3) % 4) ||
          y1 !== exp_y[((c - 1) / 3) % 4] || sc1 !== (c < 36)) begin
        errs++;
        $display("FAIL cont_c%0d st=%b dn=%b ys=%0d y=%b sc=%b want st=%b dn=%b ys=%0d y=%b sc=%b",
                 c, st1, dn1, ys1, y1, sc1, c % 3 == 0, c % 12 == 0, ((c - 1) / 3) % 4,
                 exp_y[((c - 1) / 3) % 4], c < 36);
      end
    end
    tick();
    checks++;
    if (sc1 !== 1'b0 || st1 !== 1'b0 || dn1 !== 1'b0) begin
      errs++;
      $display("FAIL cont_end sc=%b st=%b dn=%b want 0 0 0", sc1, st1, dn1);
    end
  endtask

  task automatic test_abort;
    mode = 1'b0;
    tick();
    mode = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (5) tick();
    checks++;
    if (sc1 !== 1'b1 || so1 !== 2'd1) begin
      errs++;
      $display("FAIL abort_pre sc=%b so=%0d want sc=1 so=1", sc1, so1);
    end
    mode = 1'b0;
    select_in = 2'd2;
    tick();
    checks++;
    if (sc1 !== 1'b0 || st1 !== 1'b0 || dn1 !== 1'b0 || so1 !== 2'd2 || ys1 !== 2'd1) begin
      errs++;
      $display("FAIL abort_edge sc=%b st=%b dn=%b so=%0d ys=%0d want 0 0 0 so=2 ys=1",
               sc1, st1, dn1, so1, ys1);
    end
    tick();
    checks++;
    if (ys1 !== 2'd2 || dn1 !== 1'b0) begin
      errs++;
      $display("FAIL abort_sel ys=%0d dn=%b want ys=2 dn=0", ys1, dn1);
    end
  endtask

  task automatic test_reset_mid;
    data_in = 8'hFF;
    mode = 1'b1;
    continuous = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (3) tick();
    checks++;
    if (st1 !== 1'b1 || y1 !== 2'b11 || so1 !== 2'd1) begin
      errs++;
      $display("FAIL rstmid_pre st=%b y=%b so=%0d want st=1 y=11 so=1", st1, y1, so1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({y1, ys1, so1, st1, dn1, sc1} !== 9'b0) begin
      errs++;
      $display("FAIL rstmid_async got=%b want 0", {y1, ys1, so1, st1, dn1, sc1});
    end
    #2 reset_n = 1'b1;
    continuous = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (st1 !== 1'b0 || sc1 !== 1'b0 || dn1 !== 1'b0) begin
        errs++;
        $display("FAIL rstmid_idle st=%b sc=%b dn=%b want 0 0 0", st1, sc1, dn1);
      end
    end
  endtask

  task automatic test_walk;
    mode = 1'b0;
    enable2 = 3'b000;
    for (int b = 0; b < 24; b++) begin
      data2 = 24'(1) << b;
      select2 = 3'(b % 8);
      tick();
      tick();
      checks++;
      if (y2 !== 3'(1 << (b / 8)) || ys2 !== 3'(b % 8)) begin
        errs++;
        $display("FAIL walk_b%0d y=%b ys=%0d want y=%b ys=%0d", b, y2, ys2, 3'(1 << (b / 8)), b % 8);
      end
      select2 = 3'((b + 1) % 8);
      tick();
      tick();
      checks++;
      if (y2 !== 3'b000) begin
        errs++;
        $display("FAIL walk_off_b%0d y=%b want 000", b, y2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_back_to_back();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
